// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and the fetch-to-decode payload type.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_INCR = 4;
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_out_t;
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with flush, occupancy count and full/empty flags.
module fifo_sync #(
  parameter int Depth = 4,
  parameter int W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);
  logic [W-1:0] mem [Depth];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr == AW'(Depth - 1) ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == AW'(Depth - 1) ? '0 : rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end
  assign rdata = mem[rptr];
  assign full  = count == CW'(Depth);
  assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited sequential fetch with in-order response pairing and redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               Width = 32,
  parameter logic [Width-1:0] ResetPc = '0,
  parameter int               MaxOutstanding = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               redirect_valid_i,
  input  logic [Width-1:0]   redirect_pc_i,
  output logic               mem_req_valid_o,
  output logic [Width-1:0]   mem_req_addr_o,
  input  logic               mem_req_ready_i,
  input  logic               mem_rsp_valid_i,
  input  logic [INSTR_W-1:0] mem_rsp_data_i,
  output logic               out_valid_o,
  output logic [Width-1:0]   out_pc_o,
  output logic [INSTR_W-1:0] out_instr_o,
  input  logic               out_ready_i
);
  localparam int CW = $clog2(MaxOutstanding + 1);
  logic [Width-1:0] req_pc, rsp_pc, target;
  logic [CW-1:0] inflight, inflight_nxt, drop, count;
  logic req_fire, push, pop, full, empty;
  assign target = redirect_pc_i & ~Width'(3);
  // Buffered words hold credits too, so the buffer can never overflow.
  assign mem_req_valid_o = rst_ni && (({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(MaxOutstanding));
  assign mem_req_addr_o  = req_pc;
  assign req_fire     = mem_req_valid_o && mem_req_ready_i;
  assign push         = mem_rsp_valid_i && drop == '0 && !redirect_valid_i;
  assign out_valid_o  = !empty;
  assign pop          = out_valid_o && out_ready_i;
  assign inflight_nxt = inflight + CW'(req_fire) - CW'(mem_rsp_valid_i);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_pc   <= ResetPc;
      rsp_pc   <= ResetPc;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid_i) begin
        req_pc <= target;
        rsp_pc <= target;
        drop   <= inflight_nxt;
      end else begin
        if (req_fire) req_pc <= req_pc + Width'(PC_INCR);
        if (push) rsp_pc <= rsp_pc + Width'(PC_INCR);
        if (mem_rsp_valid_i && drop != '0) drop <= drop - 1'b1;
      end
    end
  end
  fifo_sync #(.Depth(MaxOutstanding), .W(Width + INSTR_W)) u_buf (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (redirect_valid_i),
    .push  (push),
    .wdata ({rsp_pc, mem_rsp_data_i}),
    .pop   (pop),
    .rdata ({out_pc_o, out_instr_o}),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
endmodule
